// File: rtl/tile_ccff_shadow_ctrl.sv
// Double-buffered configuration-chain segment: serial shift register feeding a committed shadow.
// Define CCFF_PARITY_EN to append an even-parity flop to the chain and check it on commit.
module tile_ccff_shadow_ctrl #(
    parameter int CHAIN_LEN = 128
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst_n,
    input  logic                 IO_ISOL_N,
    input  logic                 ccff_head,
    input  logic                 ccff_shift,
    input  logic                 ccff_commit,
    input  logic                 ccff_clear,
    output logic                 ccff_tail,
    output logic [CHAIN_LEN-1:0] cfg_bits,
    output logic                 cfg_valid,
    output logic                 cfg_err,
    output logic                 io_isol_n
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 2);
`ifdef CCFF_PARITY_EN
    localparam int L = CHAIN_LEN + 1;
`else
    localparam int L = CHAIN_LEN;
`endif
    localparam logic [CNT_W-1:0] L_CNT = CNT_W'(L);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [L-1:0]           sr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CHAIN_LEN-1:0]   cfg_bits_q;
    logic                   cfg_valid_q;
    logic                   cfg_err_q;

    logic                   full;
    logic                   parity_ok;
    logic [CHAIN_LEN-1:0]   payload;
    logic [CNT_W-1:0]       cnt_inc;
    logic [L-1:0]           sr_d;

    // Parity bit is shifted in last, so it sits in sr[0] with the payload above it.
`ifdef CCFF_PARITY_EN
    assign parity_ok = ~(^sr_q);
    assign payload   = sr_q[L-1:1];
`else
    assign parity_ok = 1'b1;
    assign payload   = sr_q[CHAIN_LEN-1:0];
`endif

    assign full    = (cnt_q == L_CNT);
    assign cnt_inc = full ? cnt_q : cnt_q + CNT_W'(1);
    assign sr_d    = {sr_q[L-2:0], ccff_head};

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            cfg_bits_q  <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            // The chain keeps moving regardless of commit/clear so downstream tiles are never starved.
            if (ccff_shift) begin
                sr_q <= sr_d;
            end
            if (ccff_clear) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                cfg_bits_q  <= '0;
                cfg_valid_q <= 1'b0;
                cfg_err_q   <= 1'b0;
            end else if (ccff_commit && full && parity_ok) begin
                state_q     <= ACTIVE;
                cfg_bits_q  <= payload;
                cfg_valid_q <= 1'b1;
                cfg_err_q   <= 1'b0;
                cnt_q       <= ccff_shift ? CNT_W'(1) : '0;
            end else begin
                if (ccff_commit) begin
                    cfg_err_q <= 1'b1;
                end
                if (ccff_shift) begin
                    cnt_q <= cnt_inc;
                    if (state_q == IDLE) begin
                        state_q <= LOADING;
                    end
                end
            end
        end
    end

    assign ccff_tail = sr_q[L-1];
    assign cfg_bits  = cfg_bits_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_err   = cfg_err_q;
    assign io_isol_n = IO_ISOL_N & cfg_valid_q;

endmodule

// File: tb/tb_tile_ccff_shadow_ctrl.sv
// Directed bench for tile_ccff_shadow_ctrl at CHAIN_LEN=8; follows CCFF_PARITY_EN when defined.
module tb_tile_ccff_shadow_ctrl;

    localparam int CL = 8;
`ifdef CCFF_PARITY_EN
    localparam int TL = CL + 1;
`else
    localparam int TL = CL;
`endif

    logic          prog_clk = 1'b0;
    logic          prog_rst_n;
    logic          IO_ISOL_N;
    logic          ccff_head;
    logic          ccff_shift;
    logic          ccff_commit;
    logic          ccff_clear;
    logic          ccff_tail;
    logic [CL-1:0] cfg_bits;
    logic          cfg_valid;
    logic          cfg_err;
    logic          io_isol_n;

    int n_tests = 0;
    int n_fail  = 0;
    logic [TL-1:0] s;

    tile_ccff_shadow_ctrl #(.CHAIN_LEN(CL)) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .IO_ISOL_N  (IO_ISOL_N),
        .ccff_head  (ccff_head),
        .ccff_shift (ccff_shift),
        .ccff_commit(ccff_commit),
        .ccff_clear (ccff_clear),
        .ccff_tail  (ccff_tail),
        .cfg_bits   (cfg_bits),
        .cfg_valid  (cfg_valid),
        .cfg_err    (cfg_err),
        .io_isol_n  (io_isol_n)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // Serial stream for one tile: payload MSB-first, then (when enabled) an even-parity bit.
    function automatic logic [TL-1:0] mk(input logic [7:0] p);
`ifdef CCFF_PARITY_EN
        return {p, ^p};
`else
        return p;
`endif
    endfunction

    task automatic shift_range(input logic [TL-1:0] st, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            ccff_head  = st[i];
            ccff_shift = 1'b1;
            step();
        end
        ccff_shift = 1'b0;
    endtask

    task automatic commit();
        ccff_commit = 1'b1;
        step();
        ccff_commit = 1'b0;
    endtask

    initial begin
        prog_rst_n  = 1'b0;
        IO_ISOL_N   = 1'b1;
        ccff_head   = 1'b0;
        ccff_shift  = 1'b0;
        ccff_commit = 1'b0;
        ccff_clear  = 1'b0;
        step();
        step();
        prog_rst_n = 1'b1;
        step();

        check("rst_bits",  cfg_bits,  32'h00);
        check("rst_valid", cfg_valid, 0);
        check("rst_isol",  io_isol_n, 0);
        check("rst_tail",  ccff_tail, 0);
        check("rst_err",   cfg_err,   0);

        // Load A5; first bit (1) reaches the tail on the last shift, not before.
        s = mk(8'hA5);
        shift_range(s, TL-1, 1);
        check("tail_before", ccff_tail, 0);
        shift_range(s, 0, 0);
        check("tail_at_L", ccff_tail, 1);
        check("pre_commit_bits",  cfg_bits,  32'h00);
        check("pre_commit_valid", cfg_valid, 0);
        commit();
        check("a5_bits",  cfg_bits,  32'hA5);
        check("a5_valid", cfg_valid, 1);
        check("a5_isol",  io_isol_n, 1);
        check("a5_err",   cfg_err,   0);
        IO_ISOL_N = 1'b0;
        #1;
        check("isol_gated", io_isol_n, 0);
        IO_ISOL_N = 1'b1;

        // Underrun while A5 is live, then finish the 3C stream and commit.
        s = mk(8'h3C);
        shift_range(s, TL-1, TL-5);
        check("reprog_hold_bits", cfg_bits, 32'hA5);
        commit();
        check("underrun_err",   cfg_err,   1);
        check("underrun_bits",  cfg_bits,  32'hA5);
        check("underrun_valid", cfg_valid, 1);
        for (int i = TL-6; i >= 0; i--) begin
            ccff_head  = s[i];
            ccff_shift = 1'b1;
            step();
            check("reprog_bits",  cfg_bits,  32'hA5);
            check("reprog_valid", cfg_valid, 1);
        end
        ccff_shift = 1'b0;
        commit();
        check("3c_bits",  cfg_bits,  32'h3C);
        check("3c_valid", cfg_valid, 1);
        check("3c_err",   cfg_err,   0);

        // Commit with simultaneous shift: accepted, and the shifted bit counts toward the next load.
        s = mk(8'h66);
        shift_range(s, TL-1, 0);
        s = mk(8'hC3);
        ccff_head   = s[TL-1];
        ccff_shift  = 1'b1;
        ccff_commit = 1'b1;
        step();
        ccff_shift  = 1'b0;
        ccff_commit = 1'b0;
        check("cs_bits", cfg_bits, 32'h66);
        check("cs_err",  cfg_err,  0);
        shift_range(s, TL-2, 0);
        commit();
        check("cs_next_bits", cfg_bits, 32'hC3);
        check("cs_next_err",  cfg_err,  0);

        // Clear and commit together: clear wins.
        s = mk(8'h0F);
        shift_range(s, TL-1, 0);
        ccff_clear  = 1'b1;
        ccff_commit = 1'b1;
        step();
        ccff_clear  = 1'b0;
        ccff_commit = 1'b0;
        check("clr_valid", cfg_valid, 0);
        check("clr_bits",  cfg_bits,  32'h00);
        check("clr_isol",  io_isol_n, 0);
        check("clr_err",   cfg_err,   0);
        commit();
        check("clr_cnt_zero", cfg_err, 1);

        // Reset in the middle of shifting after a live configuration.
        s = mk(8'h81);
        shift_range(s, TL-1, 0);
        commit();
        check("81_bits", cfg_bits, 32'h81);
        s = mk(8'hFF);
        shift_range(s, TL-1, TL-4);
        ccff_head  = 1'b1;
        ccff_shift = 1'b1;
        prog_rst_n = 1'b0;
        step();
        ccff_shift = 1'b0;
        prog_rst_n = 1'b1;
        check("mrst_bits",  cfg_bits,  32'h00);
        check("mrst_valid", cfg_valid, 0);
        check("mrst_isol",  io_isol_n, 0);
        check("mrst_tail",  ccff_tail, 0);
        check("mrst_err",   cfg_err,   0);

`ifdef CCFF_PARITY_EN
        // Good parity commits; bad parity is rejected and leaves the shadow alone.
        s = {8'hA5, 1'b0};
        shift_range(s, TL-1, 0);
        commit();
        check("par_ok_bits", cfg_bits, 32'hA5);
        check("par_ok_err",  cfg_err,  0);
        s = {8'h5A, 1'b1};
        shift_range(s, TL-1, 0);
        commit();
        check("par_bad_err",   cfg_err,   1);
        check("par_bad_bits",  cfg_bits,  32'hA5);
        check("par_bad_valid", cfg_valid, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_ccff_shadow_ctrl.md
# tile_ccff_shadow_ctrl

Parametrised configuration-chain segment for a fabric tile, with double-buffered configuration. Bits shift through a CHAIN_LEN-bit shift register from `ccff_head` to `ccff_tail`. A commit pulse from the fabric programming controller copies the shift register into a shadow register that drives the tile's routing and IO muxes. The fabric can therefore be reprogrammed while the current configuration stays live. The block also gates IO isolation until a valid configuration exists and detects underrun, plus optional parity faults.

## Interface
- `CHAIN_LEN`, default 128: configuration bits owned by this tile (sum of grid_io, cbx and sb segments); must be ≥ 2.
- `CNT_W`, default $clog2(CHAIN_LEN+2): shift-counter width; derived, never overridden.
- `prog_clk`  in  1  programming clock; the block's only clock.
- `prog_rst_n`  in  1  reset, synchronous, active-low.
- `IO_ISOL_N`  in  1  global IO isolation, active-low.
- `ccff_head`  in  1  serial configuration data in.
- `ccff_shift`  in  1  shift enable; one bit advances per cycle while high.
- `ccff_commit`  in  1  single-cycle pulse; requests a shadow update.
- `ccff_clear`  in  1  single-cycle pulse; invalidates the configuration.
- `ccff_tail`  out  1  serial data out to the next tile (last chain flop).
- `cfg_bits`  out  CHAIN_LEN  shadow configuration to the mux stages.
- `cfg_valid`  out  1  shadow holds a committed configuration.
- `cfg_err`  out  1  sticky: last commit was rejected.
- `io_isol_n`  out  1  `IO_ISOL_N & cfg_valid`, combinational from registered `cfg_valid`.

## Operation
- Chain length is L: L = CHAIN_LEN, or CHAIN_LEN+1 when parity is enabled.
- Shift: when `ccff_shift` is high, `sr[0] <= ccff_head` and `sr[i] <= sr[i-1]`. `ccff_tail = sr[L-1]`.
- `cnt` increments on each shift and saturates at L. Shifting continues after saturation so downstream tiles keep receiving data.
- States:
  - IDLE: `cfg_valid`=0. The first shift moves to LOADING.
  - LOADING: shadow holds the previous configuration, or zero if none was committed.
  - ACTIVE: `cfg_valid`=1.
- Commit is accepted when `cnt == L` and the parity check passes:
  - `cfg_bits <= sr[0:CHAIN_LEN-1]`, `cfg_valid <= 1`, `cfg_err <= 0`, `cnt <= 0`.
  - Next state is ACTIVE.
- Commit is rejected when `cnt < L` (underrun) or parity fails:
  - `cfg_err <= 1`; `cfg_bits`, `cfg_valid` and `sr` unchanged; `cnt` unchanged.
  - State is unchanged.
- Commit while in ACTIVE with `cnt == L` swaps in the new configuration without dropping `cfg_valid`.
- Clear: `cfg_valid <= 0`, `cfg_bits <= 0`, `cnt <= 0`, `cfg_err <= 0`; next state IDLE. `sr` is not cleared.
- Simultaneous events, in priority order:
  - clear beats commit beats shift-only.
  - Commit and shift in the same cycle: commit evaluates `cnt` and `sr` before the shift. The shift still happens, and `cnt` becomes 1 if the commit was accepted.
- Shift in ACTIVE: state stays ACTIVE; shadow and `cfg_valid` are unaffected.

## Timing
- Reset (`prog_rst_n` low at a `prog_clk` edge):
  - `sr`, `cnt`, `cfg_bits` are 0; `cfg_valid`=0, `cfg_err`=0; state IDLE.
  - Therefore `ccff_tail`=0 and `io_isol_n`=0.
- Reset mid-shift or mid-commit discards everything. No partial shadow update is possible, because the shadow updates atomically at one edge.
- Chain latency: a bit presented on `ccff_head` with `ccff_shift` high appears on `ccff_tail` after exactly L shift cycles. Cycles without a shift do not count.
- Commit latency: `cfg_bits`, `cfg_valid` and `io_isol_n` change on the edge that samples `ccff_commit`, and are visible one cycle after the pulse.
- `cfg_err` updates on the same edge as the commit it reports.
- No combinational path from any input to `ccff_tail`.

## Configuration
- Macro: `CCFF_PARITY_EN`.
- Defined:
  - One extra flop is appended to the chain, so L = CHAIN_LEN+1.
  - The serial stream carries one parity bit per tile, shifted in last, so it sits in `sr[0]`. The CHAIN_LEN payload bits sit in `sr[1:L-1]` and are copied to `cfg_bits`.
  - A commit requires even parity: XOR of `sr[0:L-1]` == 0.
- Undefined:
  - L = CHAIN_LEN; no parity logic.
  - `cfg_err` reports underrun only.

## Test plan
All scenarios use CHAIN_LEN=8 unless stated.
- Reset, then idle: `cfg_bits`=8'h00, `cfg_valid`=0, `io_isol_n`=0 with `IO_ISOL_N`=1, `ccff_tail`=0.
- Shift 8'hA5 MSB-first, then commit:
  - `cfg_bits`=8'hA5 and `cfg_valid`=1 one cycle after the pulse; `io_isol_n`=1.
  - The first shifted bit appears on `ccff_tail` on the 8th shift.
- Commit after only 5 shifts: `cfg_err`=1; `cfg_valid` and `cfg_bits` unchanged. Three more shifts and a second commit load the shadow and clear `cfg_err`.
- Reprogram while ACTIVE:
  - With 8'hA5 live, shift 8'h3C: `cfg_bits` stays 8'hA5 throughout.
  - Commit swaps to 8'h3C with `cfg_valid` never dropping.
- Corner events:
  - Clear and commit in the same cycle: cleared, `cfg_valid`=0.
  - Commit and shift together at cnt==L: accepted, `cnt`=1 afterwards.
  - `prog_rst_n` low mid-shift: all outputs return to reset values.
- With `CCFF_PARITY_EN`, CHAIN_LEN=8:
  - Payload 8'hA5 with parity bit 0 commits.
  - Payload 8'hA5 with parity bit 1 sets `cfg_err`=1, and the shadow is unchanged.
